// File: rtl/vdg_address_sequencer.sv
// VDG display-address sequencer: walks DA through each memory row, repeats a
// row for R scanlines, then advances the row base by bytes-per-row. Emits the
// row-preset pulse (rp) whenever a new memory row begins.
module vdg_address_sequencer #(
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic                  line_start,
  input  logic                  fetch,
  input  logic                  ag,
  input  logic [2:0]            gm,
  output logic [ADDR_WIDTH-1:0] da,
  output logic                  rp,
  output logic [3:0]            row_line,
  output logic                  line_active
);

  typedef enum logic [1:0] {IDLE, WAIT_LINE, FETCH, LINE_DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] da_q, da_d;
  logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
  logic [5:0]            byte_cnt_q, byte_cnt_d;
  logic [3:0]            line_in_row_q, line_in_row_d;
  logic                  rp_q, rp_d;
  logic                  wide_q, wide_d;   // 1 = 32 bytes per row, 0 = 16
  logic [3:0]            rep_q, rep_d;     // scanlines per memory row (R)

  logic                  mode_wide;
  logic [3:0]            mode_rep;
  logic [ADDR_WIDTH-1:0] bpr;
  logic [5:0]            last_byte;
  logic                  row_last;
  logic [ADDR_WIDTH-1:0] eol_base;
  logic [3:0]            eol_line;

  // Mode table: (bytes per row, row repeat) from ag/gm; sampled only on frame_start
  always_comb begin
    mode_wide = 1'b1;
    mode_rep  = 4'd12;
    if (ag) begin
      case (gm)
        3'd0, 3'd1: begin mode_wide = 1'b0; mode_rep = 4'd3; end
        3'd2:       begin mode_wide = 1'b1; mode_rep = 4'd3; end
        3'd3:       begin mode_wide = 1'b0; mode_rep = 4'd2; end
        3'd4:       begin mode_wide = 1'b1; mode_rep = 4'd2; end
        3'd5:       begin mode_wide = 1'b0; mode_rep = 4'd1; end
        default:    begin mode_wide = 1'b1; mode_rep = 4'd1; end
      endcase
    end
  end

  // End-of-line bookkeeping shared by the completing fetch and a short line.
  // The row base advances arithmetically so a short line still steps a full row.
  always_comb begin
    bpr       = wide_q ? ADDR_WIDTH'(32) : ADDR_WIDTH'(16);
    last_byte = wide_q ? 6'd31 : 6'd15;
    row_last  = (line_in_row_q == rep_q - 4'd1);
    eol_base  = row_last ? row_base_q + bpr : row_base_q;
    eol_line  = row_last ? 4'd0 : line_in_row_q + 4'd1;
  end

  // Next-state / next-register logic; frame_start > line_start > fetch
  always_comb begin
    state_d       = state_q;
    da_d          = da_q;
    row_base_d    = row_base_q;
    byte_cnt_d    = byte_cnt_q;
    line_in_row_d = line_in_row_q;
    rp_d          = 1'b0;
    wide_d        = wide_q;
    rep_d         = rep_q;
    if (frame_start) begin
      da_d          = '0;
      row_base_d    = '0;
      byte_cnt_d    = '0;
      line_in_row_d = '0;
      rp_d          = 1'b1;
      wide_d        = mode_wide;
      rep_d         = mode_rep;
      state_d       = WAIT_LINE;
    end else begin
      case (state_q)
        WAIT_LINE, LINE_DONE: begin
          if (line_start) begin
            da_d       = row_base_q;
            byte_cnt_d = '0;
            state_d    = FETCH;
          end
        end
        FETCH: begin
          if (line_start) begin
            // short line: close out the current one, then restart at the new base
            row_base_d    = eol_base;
            line_in_row_d = eol_line;
            rp_d          = row_last;
            da_d          = eol_base;
            byte_cnt_d    = '0;
          end else if (fetch) begin
            da_d       = da_q + ADDR_WIDTH'(1);
            byte_cnt_d = byte_cnt_q + 6'd1;
            if (byte_cnt_q == last_byte) begin
              row_base_d    = eol_base;
              line_in_row_d = eol_line;
              rp_d          = row_last;
              state_d       = LINE_DONE;
            end
          end
        end
        default: ;  // IDLE waits for frame_start only
      endcase
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      da_q          <= '0;
      row_base_q    <= '0;
      byte_cnt_q    <= '0;
      line_in_row_q <= '0;
      rp_q          <= 1'b0;
      wide_q        <= 1'b1;
      rep_q         <= 4'd1;
    end else begin
      state_q       <= state_d;
      da_q          <= da_d;
      row_base_q    <= row_base_d;
      byte_cnt_q    <= byte_cnt_d;
      line_in_row_q <= line_in_row_d;
      rp_q          <= rp_d;
      wide_q        <= wide_d;
      rep_q         <= rep_d;
    end
  end

  assign da          = da_q;
  assign rp          = rp_q;
  assign row_line    = line_in_row_q;
  assign line_active = (state_q == FETCH);

endmodule

// File: tb/tb_vdg_address_sequencer.sv
// Directed bench for vdg_address_sequencer: mode table, row repetition,
// short lines, strobe priority, address wrap and mid-line reset.
module tb_vdg_address_sequencer;

  logic        clk = 1'b0;
  logic        reset, frame_start, line_start, fetch, ag;
  logic [2:0]  gm;
  logic [12:0] da;
  logic        rp;
  logic [3:0]  row_line;
  logic        line_active;

  int n_cmp = 0;
  int n_bad = 0;

  vdg_address_sequencer #(.ADDR_WIDTH(13)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .line_start(line_start),
    .fetch(fetch), .ag(ag), .gm(gm), .da(da), .rp(rp), .row_line(row_line),
    .line_active(line_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // one clock with the given strobes; outputs are sampled 1 time unit after the edge
  task automatic step(input logic fs, input logic ls, input logic f);
    frame_start = fs; line_start = ls; fetch = f;
    @(posedge clk); #1;
    frame_start = 1'b0; line_start = 1'b0; fetch = 1'b0;
  endtask

  initial begin
    reset = 1'b1; frame_start = 1'b0; line_start = 1'b0; fetch = 1'b0;
    ag = 1'b1; gm = 3'd7;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // reset state
    chk("rst_da", da, 0);
    chk("rst_rp", rp, 0);
    chk("rst_row_line", row_line, 0);
    chk("rst_active", line_active, 0);

    // IDLE ignores line_start / fetch
    step(0, 1, 0);
    chk("idle_ls_active", line_active, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1);
      chk("idle_fetch_da", da, 0);
      chk("idle_fetch_rp", rp, 0);
      chk("idle_fetch_active", line_active, 0);
    end

    // gm=7: 32 bytes, R=1
    ag = 1'b1; gm = 3'd7;
    step(1, 0, 0);
    chk("g7_fs_rp", rp, 1);
    chk("g7_fs_da", da, 0);
    chk("g7_fs_active", line_active, 0);
    step(0, 0, 1);                       // fetch ignored in WAIT_LINE
    chk("g7_wait_fetch_da", da, 0);
    chk("g7_rp_one_cycle", rp, 0);
    step(0, 1, 0);
    chk("g7_ls_da", da, 0);
    chk("g7_ls_active", line_active, 1);
    for (int i = 1; i <= 32; i++) begin
      step(0, 0, 1);
      chk("g7_fetch_da", da, i);
      chk("g7_fetch_rp", rp, (i == 32) ? 1 : 0);
    end
    chk("g7_done_active", line_active, 0);
    step(0, 0, 1);                       // fetch ignored in LINE_DONE
    chk("g7_ld_da_hold", da, 32);
    chk("g7_ld_rp_clear", rp, 0);
    step(0, 1, 0);
    chk("g7_l2_da", da, 32);
    chk("g7_l2_row_line", row_line, 0);

    // gm=0: 16 bytes, R=3
    gm = 3'd0;
    step(1, 0, 0);
    for (int l = 0; l < 4; l++) begin
      step(0, 1, 0);
      chk("g0_line_da", da, (l == 3) ? 16 : 0);
      chk("g0_line_row_line", row_line, l % 3);
      chk("g0_line_rp", rp, 0);
      for (int i = 0; i < 16; i++) step(0, 0, 1);
      chk("g0_end_rp", rp, (l == 2) ? 1 : 0);
    end

    // alpha: 32 bytes, R=12
    ag = 1'b0;
    step(1, 0, 0);
    for (int l = 0; l < 13; l++) begin
      step(0, 1, 0);
      chk("a_line_da", da, (l == 12) ? 32 : 0);
      chk("a_line_row_line", row_line, l % 12);
      if (l < 12) begin
        for (int i = 0; i < 32; i++) step(0, 0, 1);
        chk("a_end_da", da, 32);
        chk("a_end_rp", rp, (l == 11) ? 1 : 0);
      end
    end

    // gm=3 (16 bytes, R=2): short second line of a row
    ag = 1'b1; gm = 3'd3;
    step(1, 0, 0);
    step(0, 1, 0);
    for (int i = 0; i < 16; i++) step(0, 0, 1);
    chk("g3_l0_rp", rp, 0);
    step(0, 1, 0);
    chk("g3_l1_da", da, 0);
    chk("g3_l1_row_line", row_line, 1);
    for (int i = 0; i < 10; i++) step(0, 0, 1);
    chk("g3_short_da_pre", da, 10);
    step(0, 1, 0);
    chk("g3_short_rp", rp, 1);
    chk("g3_short_da", da, 16);
    chk("g3_short_row_line", row_line, 0);
    chk("g3_short_active", line_active, 1);
    gm = 3'd7;                           // must not take effect until next frame
    for (int i = 0; i < 16; i++) step(0, 0, 1);
    chk("g3_midframe_rp", rp, 0);
    chk("g3_midframe_row_line", row_line, 1);
    step(0, 1, 0);
    chk("g3_midframe_da", da, 16);

    // frame_start + line_start + fetch together mid-line
    step(0, 0, 1);
    step(0, 0, 1);
    step(1, 1, 1);
    chk("prio_da", da, 0);
    chk("prio_rp", rp, 1);
    chk("prio_active", line_active, 0);
    chk("prio_row_line", row_line, 0);
    step(0, 0, 1);
    chk("prio_wait_da", da, 0);
    chk("prio_wait_active", line_active, 0);

    // gm=7 for 256 rows: address wraps at 8192
    gm = 3'd7;
    step(1, 0, 0);
    for (int l = 0; l < 256; l++) begin
      step(0, 1, 0);
      if (l == 0 || l == 128 || l == 255) chk("wrap_row_da", da, (l * 32) % 8192);
      for (int i = 0; i < 32; i++) step(0, 0, 1);
    end
    chk("wrap_end_da", da, 0);
    step(0, 1, 0);
    chk("wrap_row256_da", da, 0);

    // reset mid-line wins over any strobe
    for (int i = 0; i < 5; i++) step(0, 0, 1);
    chk("mid_da", da, 5);
    reset = 1'b1;
    step(1, 1, 1);
    reset = 1'b0;
    chk("mrst_da", da, 0);
    chk("mrst_active", line_active, 0);
    chk("mrst_rp", rp, 0);
    step(0, 1, 0);
    step(0, 0, 1);
    chk("mrst_idle_da", da, 0);
    chk("mrst_idle_active", line_active, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
